// File: rtl/key_debounce_repeat.sv
// Push-button conditioner: per key a 2-FF synchroniser, counter debounce, a press
// strobe and optional hold-to-auto-repeat. Each key runs independently.
module key_debounce_repeat #(
    parameter int                N_KEYS       = 3,
    parameter int                CNT_W        = 26,
    parameter int                DEBOUNCE_CYC = 500000,
    parameter int                REPEAT_DLY   = 25000000,
    parameter int                REPEAT_PER   = 5000000,
    parameter logic [N_KEYS-1:0] REPEAT_MASK  = 3'b110
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic [N_KEYS-1:0] i_key_n,
    output logic [N_KEYS-1:0] o_level,
    output logic [N_KEYS-1:0] o_pulse
);

    typedef enum logic [1:0] {
        ST_REL  = 2'b00,
        ST_HOLD = 2'b01,
        ST_RPT  = 2'b10
    } key_state_e;

    localparam logic [CNT_W-1:0] DEB_TC = CNT_W'(DEBOUNCE_CYC - 1);
    localparam logic [CNT_W-1:0] DLY_TC = CNT_W'(REPEAT_DLY - 1);
    localparam logic [CNT_W-1:0] PER_TC = CNT_W'(REPEAT_PER - 1);

    logic [N_KEYS-1:0] sync1_q;
    logic [N_KEYS-1:0] sync2_q;

    // Two-stage synchroniser; resets to the released (high) level.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            sync1_q <= {N_KEYS{1'b1}};
            sync2_q <= {N_KEYS{1'b1}};
        end else begin
            sync1_q <= i_key_n;
            sync2_q <= sync1_q;
        end
    end

    for (genvar k = 0; k < N_KEYS; k++) begin : g_key
        logic [CNT_W-1:0] dcnt_q, dcnt_d;
        logic [CNT_W-1:0] rcnt_q, rcnt_d;
        logic             level_q, level_d;
        logic             pulse_q, pulse_d;
        key_state_e       state_q, state_d;
        logic             samp_s;
        logic             rise_s;
        logic             fall_s;

        assign samp_s = ~sync2_q[k];
        assign rise_s = level_d & ~level_q;
        assign fall_s = level_q & ~level_d;

        // Debounce: accept a new level after DEBOUNCE_CYC consecutive disagreeing samples.
        always_comb begin
            dcnt_d  = dcnt_q;
            level_d = level_q;
            if (samp_s == level_q) begin
                dcnt_d = {CNT_W{1'b0}};
            end else if (dcnt_q == DEB_TC) begin
                level_d = samp_s;
                dcnt_d  = {CNT_W{1'b0}};
            end else begin
                dcnt_d = dcnt_q + CNT_W'(1);
            end
        end

        // Press/repeat FSM; acts on the debounced level of this same edge so the
        // press strobe lines up with the level rise, and release beats a repeat.
        always_comb begin
            state_d = state_q;
            rcnt_d  = rcnt_q;
            pulse_d = 1'b0;
            case (state_q)
                ST_REL: begin
                    rcnt_d = {CNT_W{1'b0}};
                    if (rise_s) begin
                        pulse_d = 1'b1;
                        state_d = ST_HOLD;
                    end else begin
                        state_d = ST_REL;
                    end
                end
                ST_HOLD: begin
                    if (fall_s) begin
                        state_d = ST_REL;
                        rcnt_d  = {CNT_W{1'b0}};
                    end else if (!REPEAT_MASK[k]) begin
                        rcnt_d = {CNT_W{1'b0}};
                    end else if (rcnt_q == DLY_TC) begin
                        pulse_d = 1'b1;
                        rcnt_d  = {CNT_W{1'b0}};
                        state_d = ST_RPT;
                    end else begin
                        rcnt_d = rcnt_q + CNT_W'(1);
                    end
                end
                ST_RPT: begin
                    if (fall_s) begin
                        state_d = ST_REL;
                        rcnt_d  = {CNT_W{1'b0}};
                    end else if (rcnt_q == PER_TC) begin
                        pulse_d = 1'b1;
                        rcnt_d  = {CNT_W{1'b0}};
                    end else begin
                        rcnt_d = rcnt_q + CNT_W'(1);
                    end
                end
                default: begin
                    state_d = ST_REL;
                    rcnt_d  = {CNT_W{1'b0}};
                end
            endcase
        end

        // Per-key state registers.
        always_ff @(posedge i_clk) begin
            if (i_rst) begin
                dcnt_q  <= {CNT_W{1'b0}};
                rcnt_q  <= {CNT_W{1'b0}};
                level_q <= 1'b0;
                pulse_q <= 1'b0;
                state_q <= ST_REL;
            end else begin
                dcnt_q  <= dcnt_d;
                rcnt_q  <= rcnt_d;
                level_q <= level_d;
                pulse_q <= pulse_d;
                state_q <= state_d;
            end
        end

        assign o_level[k] = level_q;
        assign o_pulse[k] = pulse_q;
    end

endmodule

// File: tb/tb_key_debounce_repeat.sv
// Bench for key_debounce_repeat: a per-edge reference model feeds an expected-output
// queue, plus directed checks of edge timing and pulse counts.
module tb_key_debounce_repeat;

    localparam int         DEB  = 4;
    localparam int         DLY  = 10;
    localparam int         PER  = 3;
    localparam logic [2:0] MASK = 3'b110;

    logic       clk = 1'b0;
    logic       rst;
    logic [2:0] key_n;
    logic [2:0] level;
    logic [2:0] pulse;

    key_debounce_repeat #(
        .N_KEYS(3), .CNT_W(8), .DEBOUNCE_CYC(DEB),
        .REPEAT_DLY(DLY), .REPEAT_PER(PER), .REPEAT_MASK(MASK)
    ) dut (
        .i_clk(clk), .i_rst(rst), .i_key_n(key_n), .o_level(level), .o_pulse(pulse)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;

    logic [2:0] m_ff1 = 3'b111, m_ff2 = 3'b111, m_lvl = 3'b000, m_pul = 3'b000;
    int         m_run[3];
    int         m_held[3];
    logic [5:0] exp_q[$];

    logic [2:0] prev_lvl = 3'b000;
    logic [2:0] first_pv;
    int         pcount[3];
    int         rise_cyc[3];
    int         fall_cyc[3];
    int         p2q[$];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    // Reference model for the coming edge, written in terms of time held since acceptance.
    task automatic model_edge();
        logic [2:0] mask_v;
        logic       s;
        logic       rise;
        mask_v = MASK;
        if (rst) begin
            m_ff1 = 3'b111; m_ff2 = 3'b111; m_lvl = 3'b000; m_pul = 3'b000;
            for (int k = 0; k < 3; k++) begin
                m_run[k] = 0; m_held[k] = 0;
            end
        end else begin
            for (int k = 0; k < 3; k++) begin
                s = ~m_ff2[k];
                rise = 1'b0;
                m_pul[k] = 1'b0;
                if (s == m_lvl[k]) m_run[k] = 0;
                else if (m_run[k] == DEB - 1) begin
                    m_run[k] = 0; m_lvl[k] = s; rise = s;
                end else m_run[k]++;
                if (rise) begin
                    m_held[k] = 0; m_pul[k] = 1'b1;
                end else if (m_lvl[k]) begin
                    m_held[k]++;
                    m_pul[k] = mask_v[k] && (m_held[k] >= DLY) && (((m_held[k] - DLY) % PER) == 0);
                end else m_held[k] = 0;
            end
            m_ff2 = m_ff1;
            m_ff1 = key_n;
        end
        exp_q.push_back({m_lvl, m_pul});
    endtask

    task automatic step();
        logic [5:0] e;
        model_edge();
        @(posedge clk);
        #1;
        cyc++;
        if (exp_q.size() == 0) check("sb_empty", 32'd1, 32'd0);
        else begin
            e = exp_q.pop_front();
            check("sb_level", {29'd0, level}, {29'd0, e[5:3]});
            check("sb_pulse", {29'd0, pulse}, {29'd0, e[2:0]});
        end
        for (int k = 0; k < 3; k++) begin
            if (pulse[k]) pcount[k]++;
            if (level[k] && !prev_lvl[k] && rise_cyc[k] < 0) rise_cyc[k] = cyc;
            if (!level[k] && prev_lvl[k] && fall_cyc[k] < 0) fall_cyc[k] = cyc;
        end
        if (pulse[2]) p2q.push_back(cyc);
        if (pulse != 3'b000 && first_pv == 3'b000) first_pv = pulse;
        prev_lvl = level;
    endtask

    task automatic clear_stats();
        for (int k = 0; k < 3; k++) begin
            pcount[k] = 0; rise_cyc[k] = -1; fall_cyc[k] = -1;
        end
        p2q.delete();
        first_pv = 3'b000;
    endtask

    initial begin
        int k0, r0, e0;
        clear_stats();
        rst = 1'b1; key_n = 3'b111;
        step(); step();
        rst = 1'b0;
        repeat (20) step();
        check("t1_idle_level", {29'd0, level}, 32'd0);
        check("t1_idle_pulses", pcount[0] + pcount[1] + pcount[2], 32'd0);

        // Key0: press, hold, release (no repeat on bit 0)
        clear_stats();
        key_n = 3'b110; k0 = cyc + 1;
        repeat (30) step();
        key_n = 3'b111; r0 = cyc + 1;
        repeat (10) step();
        check("t2_rise_edge", rise_cyc[0], k0 + 5);
        check("t2_fall_edge", fall_cyc[0], r0 + 5);
        check("t2_pulse_cnt", pcount[0], 32'd1);

        // Key1 bounce then steady
        clear_stats();
        key_n = 3'b101; repeat (3) step();
        key_n = 3'b111; repeat (1) step();
        key_n = 3'b101; repeat (2) step();
        key_n = 3'b111; repeat (1) step();
        key_n = 3'b101; k0 = cyc + 1;
        repeat (8) step();
        key_n = 3'b111;
        repeat (10) step();
        check("t3_rise_edge", rise_cyc[1], k0 + 5);
        check("t3_pulse_cnt", pcount[1], 32'd1);

        // Key2 held: press pulse then repeats at +10, +13, ...
        clear_stats();
        key_n = 3'b011; k0 = cyc + 1;
        repeat (35) step();
        key_n = 3'b111;
        repeat (12) step();
        check("t4_pulse_cnt", pcount[2], 32'd10);
        if (p2q.size() >= 3) begin
            check("t4_press", p2q[0], k0 + 5);
            check("t4_rpt1", p2q[1], k0 + 15);
            check("t4_rpt2", p2q[2], k0 + 18);
        end else check("t4_pq_size", p2q.size(), 32'd3);

        // All keys at once
        clear_stats();
        key_n = 3'b000;
        repeat (20) step();
        key_n = 3'b111;
        repeat (12) step();
        check("t5_first_vec", {29'd0, first_pv}, 32'd7);
        check("t5_cnt0", pcount[0], 32'd1);
        check("t5_cnt1", pcount[1], 32'd5);
        check("t5_cnt2", pcount[2], 32'd5);

        // Reset while key2 is in auto-repeat
        clear_stats();
        key_n = 3'b011;
        repeat (20) step();
        rst = 1'b1;
        step();
        e0 = cyc;
        check("t6_rst_level", {29'd0, level}, 32'd0);
        check("t6_rst_pulse", {29'd0, pulse}, 32'd0);
        rst = 1'b0;
        clear_stats();
        repeat (25) step();
        check("t6_rise_edge", rise_cyc[2], e0 + 6);
        if (p2q.size() >= 3) begin
            check("t6_press", p2q[0], e0 + 6);
            check("t6_rpt1", p2q[1], e0 + 16);
            check("t6_rpt2", p2q[2], e0 + 19);
        end else check("t6_pq_size", p2q.size(), 32'd3);
        key_n = 3'b111;
        repeat (10) step();
        check("t6_final_level", {29'd0, level}, 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
